// File: rtl/unified_mem_responder_if.sv
// unified_mem_responder_if: request/response bus between a requester (master) and the unified memory responder (slave)
// Request:  req_valid, req_ready, req_write, req_instr, req_addr, req_wdata
// Response: rsp_valid, rsp_rdata, rsp_err, plus the last fetched instruction instr_q
interface unified_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_instr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] instr_q;
  modport master (
    output req_valid, req_write, req_instr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, instr_q
  );
  modport slave (
    input  req_valid, req_write, req_instr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, instr_q
  );
endinterface

// File: rtl/unified_mem_responder.sv
// unified_mem_responder: unified instruction/data RAM answering one access at a time after LATENCY wait cycles
// Ports: clk (rising-edge clock), reset (async, active-low), bus (slave side of unified_mem_responder_if)
module unified_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic                     clk,
  input logic                     reset,
  unified_mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, fetch_q;
  logic [31:0]   addr_q, wdata_q;
  logic          rsp_valid_q, rsp_err_q;
  logic [31:0]   rsp_rdata_q, instr_reg_q;
  logic [31:0]   mem_q [DEPTH_WORDS];
  logic          acc, write_c, fetch_c, err_c, enter_resp;
  logic [31:0]   addr_c, wdata_c;
  logic [AW-1:0] idx_c;
  // With LATENCY=0 the access resolves on the acceptance edge itself, so the
  // live request fields are used in IDLE and the latched copies afterwards.
  assign acc        = state_q == IDLE && bus.req_valid;
  assign write_c    = acc ? bus.req_write : write_q;
  assign fetch_c    = acc ? bus.req_instr : fetch_q;
  assign addr_c     = acc ? bus.req_addr  : addr_q;
  assign wdata_c    = acc ? bus.req_wdata : wdata_q;
  assign idx_c      = addr_c[AW+1:2];
  assign err_c      = addr_c[1:0] != 2'b00 || addr_c[31:AW+2] != '0 || (fetch_c && write_c);
  assign enter_resp = state_d == RESP;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (acc) begin
      state_d = LATENCY == 0 ? RESP : WAIT;
      cnt_d   = CNT_INIT;
    end else if (state_q == WAIT) begin
      state_d = cnt_q == 4'd0 ? RESP : WAIT;
      cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  always_comb begin
    bus.req_ready = state_q == IDLE;
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_err   = rsp_err_q;
    bus.rsp_rdata = rsp_rdata_q;
    bus.instr_q   = instr_reg_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q     <= 1'b0;
      fetch_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      instr_reg_q <= '0;
    end else begin
      if (acc) begin
        write_q <= bus.req_write;
        fetch_q <= bus.req_instr;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      rsp_valid_q <= enter_resp;
      rsp_err_q   <= enter_resp && err_c;
      rsp_rdata_q <= (enter_resp && !err_c && !write_c) ? mem_q[idx_c] : '0;
      if (state_q == RESP && fetch_q && !rsp_err_q) instr_reg_q <= rsp_rdata_q;
    end
  end
  // RAM has no reset; the reset term only blocks a commit while reset is held.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && write_c && !err_c) mem_q[idx_c] <= wdata_c;
  end
endmodule

// File: tb/tb_unified_mem_responder.sv
// tb_unified_mem_responder: scoreboard bench for unified_mem_responder (LATENCY=2 and LATENCY=0 instances)
module tb_unified_mem_responder;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          n_chk = 0;
  int          n_pass = 0;
  rsp_t        sb[$];
  logic [31:0] ref_mem [256];
  logic [31:0] ref_instr = '0;
  unified_mem_responder_if bus ();
  unified_mem_responder_if bus0 ();
  unified_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  unified_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic access(input string tag, input bit wr, input bit ins, input logic [31:0] addr, input logic [31:0] wd);
    rsp_t e, g;
    int   n;
    bit   err;
    err     = addr[1:0] != 2'b00 || addr >= 32'd1024 || (ins && wr);
    e.err   = err;
    e.rdata = (err || wr) ? 32'd0 : ref_mem[addr[9:2]];
    if (!err && wr) ref_mem[addr[9:2]] = wd;
    sb.push_back(e);
    @(negedge clk);
    check({tag, ":ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_instr = ins;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid) break;
      if (n == 1) check({tag, ":busy"}, 32'(bus.req_ready), 32'd0);
    end
    check({tag, ":lat"}, 32'(n), 32'd3);
    g = sb.pop_front();
    check({tag, ":rdata"}, bus.rsp_rdata, g.rdata);
    check({tag, ":err"}, 32'(bus.rsp_err), 32'(g.err));
    if (!err && ins) ref_instr = g.rdata;
    @(negedge clk);
    check({tag, ":instr"}, bus.instr_q, ref_instr);
    check({tag, ":idle"}, {bus.rsp_valid, bus.rsp_err, 30'd0} | bus.rsp_rdata, 32'd0);
  endtask
  initial begin
    int acc, rsp, acc0, rsp0, hits;
    bit prev0;
    bus.req_valid = 0; bus.req_write = 0; bus.req_instr = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus0.req_valid = 0; bus0.req_write = 0; bus0.req_instr = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst:ready", 32'(bus.req_ready), 32'd1);
    check("rst:valid", 32'(bus.rsp_valid), 32'd0);
    check("rst:err", 32'(bus.rsp_err), 32'd0);
    check("rst:rdata", bus.rsp_rdata, 32'd0);
    check("rst:instr", bus.instr_q, 32'd0);
    reset = 1'b1;
    access("st10", 1, 0, 32'h10, 32'hDEADBEEF);
    access("ld10", 0, 0, 32'h10, 32'h0);
    access("st0", 1, 0, 32'h0, 32'h00500093);
    access("fe0", 0, 1, 32'h0, 32'h0);
    access("ld10b", 0, 0, 32'h10, 32'h0);
    access("ld6", 0, 0, 32'h6, 32'h0);
    access("st400", 1, 0, 32'h400, 32'hFFFFFFFF);
    access("ld0", 0, 0, 32'h0, 32'h0);
    access("fewr", 1, 1, 32'h0, 32'hBAD0BAD0);
    access("ld0b", 0, 0, 32'h0, 32'h0);
    access("st3fc", 1, 0, 32'h3FC, 32'hCAFEF00D);
    access("ld3fc", 0, 0, 32'h3FC, 32'h0);
    access("fe3fc", 0, 1, 32'h3FC, 32'h0);
    access("fe2", 0, 1, 32'h2, 32'h0);
    access("st20", 1, 0, 32'h20, 32'h11111111);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_instr = 1'b0;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h22222222;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort:ready", 32'(bus.req_ready), 32'd1);
    check("abort:valid", 32'(bus.rsp_valid), 32'd0);
    check("abort:instr", bus.instr_q, 32'd0);
    ref_instr = '0;
    @(negedge clk);
    reset = 1'b1;
    hits = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) hits++;
    end
    check("abort:norsp", 32'(hits), 32'd0);
    access("ld20", 0, 0, 32'h20, 32'h0);
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 32'h10; bus0.req_wdata = 32'h12345678;
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;
    @(negedge clk);
    check("l0:st", 32'(bus0.rsp_valid), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_instr = 1'b0; bus.req_addr = 32'h10;
    bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_instr = 1'b0; bus0.req_addr = 32'h10;
    acc = 0; rsp = 0; acc0 = 0; rsp0 = 0; prev0 = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (bus.req_ready) acc++;
      if (bus.rsp_valid) begin
        rsp++;
        check("strm:rdata", bus.rsp_rdata, 32'hDEADBEEF);
      end
      if (bus0.rsp_valid) begin
        rsp0++;
        check("l0:follow", 32'(prev0), 32'd1);
        check("l0:rdata", bus0.rsp_rdata, 32'h12345678);
      end
      prev0 = bus0.req_ready;
      if (bus0.req_ready) acc0++;
    end
    bus.req_valid = 1'b0;
    bus0.req_valid = 1'b0;
    check("strm:acc", 32'(acc), 32'd4);
    check("strm:rsp", 32'(rsp), 32'd4);
    check("l0:acc", 32'(acc0), 32'd8);
    check("l0:rsp", 32'(rsp0), 32'd8);
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
